// File: rtl/issue_ctrl_pkg.sv
// Shared types and operand-use helpers for the issue stage.
package issue_ctrl_pkg;

    localparam int LS_STORE_BIT = 3;

    typedef enum logic [0:0] {
        ISSUE_RUN  = 1'b0,
        ISSUE_TRAP = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic        inst_invalid;
        logic        rs1_pc;
        logic [4:0]  rs1_addr;
        logic        rs2_imm;
        logic [4:0]  rs2_addr;
        logic [3:0]  loadstore;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
    } instruction_t;

    function automatic logic reads_rs1(input instruction_t ins);
        return !ins.rs1_pc && (ins.rs1_addr != 5'd0);
    endfunction

    // Stores read rs2 as data even though their address offset is an immediate.
    function automatic logic reads_rs2(input instruction_t ins);
        return (ins.rs2_addr != 5'd0) && (!ins.rs2_imm || ins.loadstore[LS_STORE_BIT]);
    endfunction

    function automatic logic is_load(input instruction_t ins);
        return (ins.loadstore != 4'd0) && !ins.loadstore[LS_STORE_BIT];
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder-side and execute-side handshake bundle of the issue stage.
interface issue_ctrl_if #(
    parameter int CNT_W = 32
);
    import issue_ctrl_pkg::*;

    logic               i_valid;
    instruction_t       i_instr;
    logic               o_ready;
    logic               o_valid;
    instruction_t       o_instr;
    logic               i_ready;
    logic               i_load_done;
    logic               i_flush;
    logic               o_illegal;
    logic [CNT_W-1:0]   o_stall_cycles;

    modport master (
        output i_valid, i_instr, i_ready, i_load_done, i_flush,
        input  o_ready, o_valid, o_instr, o_illegal, o_stall_cycles
    );

    modport slave (
        input  i_valid, i_instr, i_ready, i_load_done, i_flush,
        output o_ready, o_valid, o_instr, o_illegal, o_stall_cycles
    );

endinterface

// File: rtl/issue_ctrl_load_scoreboard.sv
// In-order FIFO of outstanding load destinations with a combinational busy mask.
module load_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic [4:0]                  i_push_rd,
    input  logic                        i_pop,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [31:0]                 o_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]     r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_rd;
    end

    always_comb begin : busy_mask
        logic [PW-1:0] v_idx;
        o_busy = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rd_ptr + PW'(k);
            if (CW'(k) < r_count) o_busy[r_mem[v_idx]] = 1'b1;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage register with load-use/WAW hazard stalls, flush and illegal-instruction trap.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int LOAD_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(LOAD_DEPTH) + 1;

    issue_state_t       r_state;
    logic               r_valid;
    instruction_t       r_instr;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_stall;

    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [31:0]        w_sb_busy;
    logic [31:0]        w_busy;
    logic               w_pending;
    logic               w_sb_full;
    logic               w_hazard;
    logic               w_ready;
    logic               w_accept;
    logic               w_consume;
    logic               w_push;
    logic               w_stall;

    assign w_pending = r_valid && is_load(r_instr) && (r_instr.rd_addr != 5'd0);
    assign w_busy    = w_sb_busy |
                       ((r_valid && is_load(r_instr)) ? (32'd1 << r_instr.rd_addr) : 32'd0);
    // A load sitting in the issue register already owns a FIFO slot once consumed.
    assign w_sb_full = w_full || (w_pending && (w_count == CW'(LOAD_DEPTH - 1)));

    assign w_hazard  = bus.i_valid &&
                       ((reads_rs1(bus.i_instr) && w_busy[bus.i_instr.rs1_addr]) ||
                        (reads_rs2(bus.i_instr) && w_busy[bus.i_instr.rs2_addr]) ||
                        ((bus.i_instr.rd_addr != 5'd0) && w_busy[bus.i_instr.rd_addr]) ||
                        (is_load(bus.i_instr) && w_sb_full));

    assign w_ready   = !i_rst && (r_state == ISSUE_RUN) && !bus.i_flush && !w_hazard &&
                       (!r_valid || bus.i_ready);
    assign w_accept  = bus.i_valid && w_ready;
    assign w_consume = r_valid && bus.i_ready && !bus.i_flush;
    assign w_push    = w_consume && w_pending;
    assign w_stall   = w_hazard && (r_state == ISSUE_RUN) && !bus.i_flush;

    load_scoreboard #(.DEPTH(LOAD_DEPTH)) u_sb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (w_push),
        .i_push_rd (r_instr.rd_addr),
        .i_pop     (bus.i_load_done && !w_empty),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_busy    (w_sb_busy)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ISSUE_RUN;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_illegal <= 1'b0;
            r_stall   <= '0;
        end else begin
            if (w_stall && (r_stall != {CNT_W{1'b1}})) r_stall <= r_stall + CNT_W'(1);
            if (bus.i_flush) begin
                r_valid   <= 1'b0;
                r_state   <= ISSUE_RUN;
                r_illegal <= 1'b0;
            end else if (w_accept && bus.i_instr.inst_invalid) begin
                r_valid   <= 1'b0;
                r_state   <= ISSUE_TRAP;
                r_illegal <= 1'b1;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_instr   <= bus.i_instr;
            end else if (w_consume) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign bus.o_ready        = w_ready;
    assign bus.o_valid        = r_valid;
    assign bus.o_instr        = r_instr;
    assign bus.o_illegal      = r_illegal;
    assign bus.o_stall_cycles = r_stall;

endmodule
